gray_ptr_monitor: RTL and testbench
===================================

# gray_ptr_monitor

Pointer-status stage that sits directly downstream of the GrayCounter in the FIFO pointer path. It takes the peer GrayCounter's Gray output (readGray, asynchronous to this clock) and the local GrayCounter's binary output (readBin). It synchronizes the Gray value, converts it to binary, and produces registered occupancy and full/empty/almost flags. It also watches the synchronized Gray stream for illegal multi-bit steps and reports them as a sticky error.

## Interface
Parameters:
- width, 10, pointer width; must match the connected GrayCounters. DEPTH = 2^(width-1).
- SYNC_STAGES, 2, synchronizer flops on remoteGray; legal range 2..4.
- MODE, 0, 0 = read side (count = syncBin - localBin); 1 = write side (count = localBin - syncBin).
- ALMOST_FULL, DEPTH-4, almostFull threshold.
- ALMOST_EMPTY, 4, almostEmpty threshold.

Ports (single clock; reset is asynchronous and active-low):
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- remoteGray  input  width  peer pointer in Gray code; asynchronous to CLK.
- localBin  input  width  local pointer in binary; synchronous to CLK.
- syncBin  output  width  synchronized, binary-converted remote pointer.
- count  output  width  occupancy, 0..DEPTH.
- empty, full, almostEmpty, almostFull  output  1 each  status flags.
- error  output  1  sticky protocol error.
- clearError__ENA  input  1  method enable: clear error.
- clearError__RDY  output  1  constant 1.
- readCount__RDY  output  1  high when error == 0.

## Operation
- Sync chain: sg[0] <= remoteGray, then sg[i] <= sg[i-1]. The final stage is gs = sg[SYNC_STAGES-1].
- Gray-to-binary, combinational from gs: b[width-1] = gs[width-1]; b[i] = b[i+1] ^ gs[i]. The result is registered into syncBin.
- gsPrev is a register holding the previous gs.
- Occupancy diff is computed mod 2^width according to MODE, from registered syncBin and the current localBin. The result is registered into count.
- Flags are computed from the new count value and registered in the same cycle as count:
  - empty = (count == 0)
  - full = (count == DEPTH)
  - almostFull = (count >= ALMOST_FULL)
  - almostEmpty = (count <= ALMOST_EMPTY)
- Error set conditions, evaluated each cycle:
  - popcount(gs ^ gsPrev) > 1, or
  - diff > DEPTH (pointer overrun).
- Error is sticky.
- clearError__ENA clears error at the next edge. If a set condition occurs in the same cycle, set wins.
- Wrap-around: all arithmetic is modulo 2^width. The transition from all-ones back to 0 is a legal single-bit Gray step and must not set error.
- When count > DEPTH would result, count saturates at DEPTH. full asserts and error sets.
- Reset values:
  - sg[*], gsPrev, syncBin, count = 0.
  - empty = 1, almostEmpty = 1.
  - full = 0, almostFull = 0.
  - error = 0.
  - readCount__RDY = 1.
- gsPrev resets to 0 so that a reset peer does not raise error. Reset can assert mid-operation at any time; all state returns to the reset values immediately, with no wait for CLK.

## Timing
- remoteGray change to syncBin update: SYNC_STAGES+1 rising edges.
- remoteGray change to count/flags update: SYNC_STAGES+2 edges.
- localBin change to count/flags update: 1 edge.
- Error latency:
  - Gray-step violation: flagged at the edge after the bad value reaches gs, i.e. SYNC_STAGES+1 edges after the remoteGray change.
  - Overrun: flagged at the same edge count updates.
- clearError__ENA high at edge N: error is 0 after N, provided no set condition was present at N.
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- After nRST deasserts, the first valid status appears at edge SYNC_STAGES+2.

## Test plan
- Reset, width=4, MODE=0: assert nRST=0 mid-run with count=5. Required: count=0, empty=1, almostEmpty=1, error=0 immediately. After release with remoteGray=0 and localBin=0, outputs are unchanged.
- Read-side fill, MODE=0, SYNC_STAGES=2: step remoteGray 0→1→3→2 (binary 3) with localBin=0. Required: syncBin=3 three edges after the last step, count=3 and almostEmpty=1 one edge later, empty=0.
- Full and wrap, MODE=1: hold localBin=8, remoteGray=Gray(0). Required: count=8, full=1, almostFull=1. Then localBin=0 (wrapped 16→0) with remoteGray=Gray(8)=4'b1100. Required: count=8, full=1, error=0.
- Illegal Gray step: remoteGray jumps 4'b0000→4'b0011. Required: error=1 at edge 3 and readCount__RDY=0. Pulse clearError__ENA one cycle while the input is stable. Required: error=0 on the next edge.
- Overrun, MODE=1: localBin=9, syncBin=0. Required: count=8, full=1, error=1.
- Simultaneous set and clear: hold clearError__ENA=1 while a bad Gray step reaches gs. Required: error stays 1.

Source files
------------

// File: rtl/gray_ptr_monitor.sv
// Gray pointer monitor: synchronizes a remote Gray pointer, converts it
// to binary and derives registered occupancy, status flags and a sticky error.
module gray_ptr_monitor #(
    parameter int width        = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int MODE         = 0,
    parameter int ALMOST_FULL  = (1 << (width - 1)) - 4,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [width-1:0] remoteGray,
    input  logic [width-1:0] localBin,
    output logic [width-1:0] syncBin,
    output logic [width-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             almostEmpty,
    output logic             almostFull,
    output logic             error,
    input  logic             clearError__ENA,
    output logic             clearError__RDY,
    output logic             readCount__RDY
);

    localparam logic [width-1:0] DEPTH = width'(1 << (width - 1));
    localparam logic [width-1:0] AF_TH = width'(ALMOST_FULL);
    localparam logic [width-1:0] AE_TH = width'(ALMOST_EMPTY);

    logic [width-1:0] sg_q [SYNC_STAGES];
    logic [width-1:0] gs;
    logic [width-1:0] gsPrev_q;
    logic [width-1:0] syncBin_q, syncBin_d;
    logic [width-1:0] count_q, count_d;
    logic [width-1:0] diff;
    logic [width-1:0] delta;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             aempty_q, aempty_d;
    logic             afull_q, afull_d;
    logic             error_q, error_d;
    logic             grayBad;
    logic             overrun;

    assign gs = sg_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous remote pointer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sg_q <= '{default: '0};
        end else begin
            sg_q[0] <= remoteGray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sg_q[i] <= sg_q[i-1];
            end
        end
    end

    // Gray to binary: bit i is the XOR of all Gray bits at or above i
    always_comb begin
        syncBin_d = '0;
        for (int i = 0; i < width; i++) begin
            syncBin_d[i] = ^(gs >> i);
        end
    end

    // Occupancy, saturation and error set/clear decisions
    always_comb begin
        if (MODE == 1) begin
            diff = localBin - syncBin_q;
        end else begin
            diff = syncBin_q - localBin;
        end
        overrun  = (diff > DEPTH);
        count_d  = overrun ? DEPTH : diff;
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH);
        afull_d  = (count_d >= AF_TH);
        aempty_d = (count_d <= AE_TH);
        // More than one bit changed between consecutive Gray samples
        delta    = gs ^ gsPrev_q;
        grayBad  = ((delta & (delta - 1'b1)) != '0);
        if (grayBad || overrun) begin
            error_d = 1'b1;
        end else if (clearError__ENA) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // Status registers; reset leaves the pointers looking empty
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            gsPrev_q  <= '0;
            syncBin_q <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            aempty_q  <= 1'b1;
            afull_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            gsPrev_q  <= gs;
            syncBin_q <= syncBin_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            aempty_q  <= aempty_d;
            afull_q   <= afull_d;
            error_q   <= error_d;
        end
    end

    assign syncBin         = syncBin_q;
    assign count           = count_q;
    assign empty           = empty_q;
    assign full            = full_q;
    assign almostEmpty     = aempty_q;
    assign almostFull      = afull_q;
    assign error           = error_q;
    assign clearError__RDY = 1'b1;
    assign readCount__RDY  = ~error_q;

endmodule

// File: tb/tb_gray_ptr_monitor.sv
// Bench for gray_ptr_monitor: read-side and write-side instances at width 4,
// expected status vectors queued at stimulus time and popped at sample time.
module tb_gray_ptr_monitor;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [3:0] remoteGray;
    logic [3:0] localBin;
    logic       clr;

    logic [3:0] sb0, cnt0, sb1, cnt1;
    logic       e0, f0, ae0, af0, er0, crdy0, rrdy0;
    logic       e1, f1, ae1, af1, er1, crdy1, rrdy1;

    logic [12:0] obs0, obs1, exp_v;
    logic [12:0] sbq[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    gray_ptr_monitor #(.width(4), .SYNC_STAGES(2), .MODE(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .remoteGray(remoteGray), .localBin(localBin),
        .syncBin(sb0), .count(cnt0), .empty(e0), .full(f0),
        .almostEmpty(ae0), .almostFull(af0), .error(er0),
        .clearError__ENA(clr), .clearError__RDY(crdy0),
        .readCount__RDY(rrdy0)
    );

    gray_ptr_monitor #(.width(4), .SYNC_STAGES(2), .MODE(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .remoteGray(remoteGray), .localBin(localBin),
        .syncBin(sb1), .count(cnt1), .empty(e1), .full(f1),
        .almostEmpty(ae1), .almostFull(af1), .error(er1),
        .clearError__ENA(clr), .clearError__RDY(crdy1),
        .readCount__RDY(rrdy1)
    );

    assign obs0 = {cnt0, sb0, e0, f0, ae0, af0, er0};
    assign obs1 = {cnt1, sb1, e1, f1, ae1, af1, er1};

    // {count, syncBin, empty, full, almostEmpty, almostFull, error}
    function automatic logic [12:0] mk(input logic [3:0] c, input logic [3:0] s,
                                       input logic e, input logic f,
                                       input logic ae, input logic af,
                                       input logic er);
        return {c, s, e, f, ae, af, er};
    endfunction

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        remoteGray = '0;
        localBin = '0;
        clr = 1'b0;
        tick(2);
        nRST = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        remoteGray = '0;
        localBin = '0;
        clr = 1'b0;
        sbq.push_back(mk(4'd0, 4'd0, 1, 0, 1, 0, 0));
        sbq.push_back(mk(4'd0, 4'd0, 1, 0, 1, 0, 0));
        tick(3);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL reset_d0: got %b want %b", obs0, exp_v);
        end
        exp_v = sbq.pop_front();
        vectors++;
        if (obs1 !== exp_v) begin
            miscompares++;
            $display("FAIL reset_d1: got %b want %b", obs1, exp_v);
        end
        vectors++;
        if ({rrdy0, crdy0, rrdy1, crdy1} !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_rdy: got %b want 1111",
                     {rrdy0, crdy0, rrdy1, crdy1});
        end
        // read side: 0 - 11 = 5 mod 16
        nRST = 1'b1;
        tick(1);
        localBin = 4'd11;
        sbq.push_back(mk(4'd5, 4'd0, 0, 0, 0, 1, 0));
        tick(2);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL reset_pre_count5: got %b want %b", obs0, exp_v);
        end
        // async assertion mid-cycle, away from any clock edge
        #2 nRST = 1'b0;
        sbq.push_back(mk(4'd0, 4'd0, 1, 0, 1, 0, 0));
        #1;
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL reset_async: got %b want %b", obs0, exp_v);
        end
        localBin = 4'd0;
        tick(1);
        nRST = 1'b1;
        sbq.push_back(mk(4'd0, 4'd0, 1, 0, 1, 0, 0));
        tick(5);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", obs0, exp_v);
        end
    endtask

    task automatic test_read_fill();
        do_reset();
        remoteGray = 4'b0001;
        tick(1);
        remoteGray = 4'b0011;
        tick(1);
        remoteGray = 4'b0010;
        sbq.push_back(mk(4'd2, 4'd3, 0, 0, 1, 0, 0));
        sbq.push_back(mk(4'd3, 4'd3, 0, 0, 1, 0, 0));
        tick(3);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL fill_syncbin: got %b want %b", obs0, exp_v);
        end
        tick(1);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL fill_count: got %b want %b", obs0, exp_v);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        localBin = 4'd8;
        sbq.push_back(mk(4'd8, 4'd0, 0, 1, 0, 1, 0));
        tick(2);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs1 !== exp_v) begin
            miscompares++;
            $display("FAIL wrap_full: got %b want %b", obs1, exp_v);
        end
        // peer catches up one legal Gray step per cycle
        for (int i = 1; i <= 8; i++) begin
            remoteGray = gray(4'(i));
            tick(1);
        end
        sbq.push_back(mk(4'd0, 4'd8, 1, 0, 1, 0, 0));
        tick(4);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs1 !== exp_v) begin
            miscompares++;
            $display("FAIL wrap_drain: got %b want %b", obs1, exp_v);
        end
        // local pointer wraps 16 -> 0 while peer sits at 8
        localBin = 4'd0;
        sbq.push_back(mk(4'd8, 4'd8, 0, 1, 0, 1, 0));
        tick(1);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs1 !== exp_v) begin
            miscompares++;
            $display("FAIL wrap_local: got %b want %b", obs1, exp_v);
        end
        // peer crosses Gray 1000 -> 0000
        for (int i = 9; i <= 16; i++) begin
            remoteGray = gray(4'(i));
            tick(1);
        end
        sbq.push_back(mk(4'd0, 4'd0, 1, 0, 1, 0, 0));
        tick(4);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs1 !== exp_v) begin
            miscompares++;
            $display("FAIL wrap_remote: got %b want %b", obs1, exp_v);
        end
    endtask

    task automatic test_illegal_gray();
        do_reset();
        remoteGray = 4'b0011;
        sbq.push_back(mk(4'd0, 4'd2, 1, 0, 1, 0, 1));
        tick(3);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_err: got %b want %b", obs0, exp_v);
        end
        vectors++;
        if (rrdy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_rdy: got %b want 0", rrdy0);
        end
        clr = 1'b1;
        sbq.push_back(mk(4'd2, 4'd2, 0, 0, 1, 0, 0));
        tick(1);
        clr = 1'b0;
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_clear: got %b want %b", obs0, exp_v);
        end
        vectors++;
        if (rrdy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_rdy_back: got %b want 1", rrdy0);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        localBin = 4'd9;
        sbq.push_back(mk(4'd8, 4'd0, 0, 1, 0, 1, 1));
        tick(1);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs1 !== exp_v) begin
            miscompares++;
            $display("FAIL overrun: got %b want %b", obs1, exp_v);
        end
        vectors++;
        if (rrdy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_rdy: got %b want 0", rrdy1);
        end
        // error stays sticky once the pointer is back in range
        localBin = 4'd3;
        sbq.push_back(mk(4'd3, 4'd0, 0, 0, 1, 0, 1));
        tick(2);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs1 !== exp_v) begin
            miscompares++;
            $display("FAIL overrun_sticky: got %b want %b", obs1, exp_v);
        end
    endtask

    task automatic test_set_and_clear();
        do_reset();
        clr = 1'b1;
        remoteGray = 4'b0011;
        sbq.push_back(mk(4'd0, 4'd2, 1, 0, 1, 0, 1));
        tick(3);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL setclr_set_wins: got %b want %b", obs0, exp_v);
        end
        clr = 1'b0;
        sbq.push_back(mk(4'd2, 4'd2, 0, 0, 1, 0, 1));
        tick(1);
        exp_v = sbq.pop_front();
        vectors++;
        if (obs0 !== exp_v) begin
            miscompares++;
            $display("FAIL setclr_hold: got %b want %b", obs0, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_read_fill();
        test_full_wrap();
        test_illegal_gray();
        test_overrun();
        test_set_and_clear();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
